// File: rtl/prover_shuffle_v_multi.sv
// prover_shuffle_v_multi: multi-channel V-value shuffler between the per-layer
// V evaluators and the sumcheck prover cores. Holds NCH channels of NIN field
// elements in one register bank and, per accepted step, applies a perfect
// unshuffle (index rotate-left), a perfect shuffle (index rotate-right) or a
// hold to every channel at once. Each load or step takes PLSTAGES cycles.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   en           request one step (honoured only while ready=1)
//   restart      capture v_in, clear round, abort any step (highest priority)
//   mode         00 hold, 01 unshuffle, 10 shuffle, 11 hold
//   v_in         v_in[c][i], NCH x NIN elements
//   ready        idle, accepts en
//   ready_pulse  one-cycle completion strobe
//   round        net unshuffle count mod LOG2N
//   v_out        v_out[c][j] = bank[c][j], j < NGATES

`ifndef F_NBITS
`define F_NBITS 64
`endif

module prover_shuffle_v_multi #(
    parameter int unsigned NGATES   = 15,
    parameter int unsigned NCH      = 3,
    parameter int unsigned PLSTAGES = 2,
    parameter int unsigned WIDTH    = `F_NBITS,
    localparam int unsigned NIN     = 1 << $clog2(NGATES),
    localparam int unsigned LOG2N   = $clog2(NIN),
    localparam int unsigned RW      = $clog2(LOG2N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] v_in  [NCH][NIN],
    output logic             ready,
    output logic             ready_pulse,
    output logic [RW-1:0]    round,
    output logic [WIDTH-1:0] v_out [NCH][NGATES]
);

    localparam int unsigned CW = (PLSTAGES > 1) ? $clog2(PLSTAGES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [RW-1:0]      round_q, round_d;
    logic               ready_q, ready_d;
    logic               pulse_q, pulse_d;
    logic [WIDTH-1:0]   bank_q   [NCH][NIN];
    logic [WIDTH-1:0]   bank_d   [NCH][NIN];
    logic [WIDTH-1:0]   shadow_q [NCH][NIN];
    logic [WIDTH-1:0]   shadow_d [NCH][NIN];
    logic               done_c;

    // Source index for unshuffle: rotate the LOG2N-bit index left by one.
    function automatic int unsigned rotl_idx(input int unsigned i);
        return ((i << 1) | (i >> (LOG2N - 1))) & (NIN - 1);
    endfunction

    // Source index for shuffle: rotate the LOG2N-bit index right by one.
    function automatic int unsigned rotr_idx(input int unsigned i);
        return ((i >> 1) | (i << (LOG2N - 1))) & (NIN - 1);
    endfunction

    // Next-state, round and bank update; bank only changes at completion.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        round_d  = round_q;
        pulse_d  = 1'b0;
        bank_d   = bank_q;
        shadow_d = shadow_q;
        done_c   = (state_q != S_IDLE) && (cnt_q == CW'(PLSTAGES - 1));

        if (restart) begin
            shadow_d = v_in;
            state_d  = S_LOAD;
            cnt_d    = '0;
            round_d  = '0;
        end else if (state_q == S_IDLE) begin
            if (en) begin
                mode_d  = mode;
                state_d = S_STEP;
                cnt_d   = '0;
            end
        end else if (!done_c) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pulse_d = 1'b1;
            if (state_q == S_LOAD) begin
                bank_d = shadow_q;
            end else begin
                case (mode_q)
                    2'b01: begin
                        for (int c = 0; c < NCH; c++)
                            for (int unsigned i = 0; i < NIN; i++)
                                bank_d[c][i] = bank_q[c][rotl_idx(i)];
                        round_d = (round_q == RW'(LOG2N - 1)) ? '0 : round_q + RW'(1);
                    end
                    2'b10: begin
                        for (int c = 0; c < NCH; c++)
                            for (int unsigned i = 0; i < NIN; i++)
                                bank_d[c][i] = bank_q[c][rotr_idx(i)];
                        round_d = (round_q == '0) ? RW'(LOG2N - 1) : round_q - RW'(1);
                    end
                    default: ;
                endcase
            end
        end

        ready_d = (state_d == S_IDLE);
    end

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            round_q <= '0;
            ready_q <= 1'b1;
            pulse_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < NIN; i++) begin
                    bank_q[c][i]   <= '0;
                    shadow_q[c][i] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            round_q  <= round_d;
            ready_q  <= ready_d;
            pulse_q  <= pulse_d;
            bank_q   <= bank_d;
            shadow_q <= shadow_d;
        end
    end

    assign ready       = ready_q;
    assign ready_pulse = pulse_q;
    assign round       = round_q;

    // Only the first NGATES slots of each channel are visible.
    always_comb begin
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < NGATES; j++)
                v_out[c][j] = bank_q[c][j];
    end

endmodule
